// File: rtl/serial_alu_pkg.sv
// rtl/serial_alu_pkg.sv - shared ALU opcode and FSM state encodings
package serial_alu_pkg;

    localparam logic [1:0] ALU_AND = 2'b00;
    localparam logic [1:0] ALU_OR  = 2'b01;
    localparam logic [1:0] ALU_ADD = 2'b10;
    localparam logic [1:0] ALU_SUB = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/alu_bit_slice.sv
// rtl/alu_bit_slice.sv - combinational 1-bit AND/OR/ADD/SUB slice
module alu_bit_slice
    import serial_alu_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    input  logic [1:0] aluctr,
    output logic       d,
    output logic       cout
);

    logic bx;

    // Subtraction is a + ~b + cin, so only the b leg is inverted.
    assign bx = (aluctr == ALU_SUB) ? ~b : b;

    always_comb begin
        d    = 1'b0;
        cout = 1'b0;
        case (aluctr)
            ALU_AND: d = a & b;
            ALU_OR:  d = a | b;
            ALU_ADD, ALU_SUB: begin
                d    = a ^ bx ^ cin;
                cout = (a & bx) | (a & cin) | (bx & cin);
            end
            default: d = 1'b0;
        endcase
    end

endmodule

// File: rtl/serial_alu.sv
// rtl/serial_alu.sv - bit-serial ALU reusing one slice over WIDTH cycles, LSB first
module serial_alu
    import serial_alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c,
    input  logic [1:0]       aluctr,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             e
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic [1:0]       op;
    logic [CW-1:0]    cnt;
    logic             sum;
    logic             cout;

    alu_bit_slice u_slice (
        .a      (sa[0]),
        .b      (sb[0]),
        .cin    (carry),
        .aluctr (op),
        .d      (sum),
        .cout   (cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            sa    <= '0;
            sb    <= '0;
            res   <= '0;
            carry <= 1'b0;
            op    <= 2'b00;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            d     <= '0;
            e     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        carry <= c;
                        op    <= aluctr;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= ST_RUN;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    sa    <= sa >> 1;
                    sb    <= sb >> 1;
                    res   <= {sum, res[WIDTH-1:1]};
                    carry <= cout;
                    cnt   <= cnt + 1'b1;
                    // Slice cout is already 0 for logic ops, so e needs no op check.
                    if (cnt == CW'(WIDTH - 1)) begin
                        d     <= {sum, res[WIDTH-1:1]};
                        e     <= cout;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_alu.sv
// tb/tb_serial_alu.sv - self-checking bench for serial_alu
module tb_serial_alu;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             c = 1'b0;
    logic [1:0]       aluctr = 2'b00;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             e;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    serial_alu #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .c      (c),
        .aluctr (aluctr),
        .busy   (busy),
        .done   (done),
        .d      (d),
        .e      (e)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [WIDTH:0] alu_ref(input logic [1:0] op, input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y, input logic ci);
        logic [WIDTH-1:0] ny;
        ny = ~y;
        case (op)
            2'b00:   return {1'b0, x & y};
            2'b01:   return {1'b0, x | y};
            2'b10:   return {1'b0, x} + {1'b0, y} + (WIDTH + 1)'(ci);
            default: return {1'b0, x} + {1'b0, ny} + (WIDTH + 1)'(ci);
        endcase
    endfunction

    // Transaction-level model: accept when idle, finish WIDTH edges later.
    logic             m_busy = 0, m_done = 0, m_e = 0;
    logic [WIDTH-1:0] m_d = '0;
    logic [WIDTH:0]   m_res = '0;
    int               m_left = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_done = 0; m_d = '0; m_e = 0; m_left = 0;
        end else begin
            m_done = 0;
            if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    {m_e, m_d} = m_res;
                    m_done = 1;
                    m_busy = 0;
                end
            end else if (start) begin
                m_res  = alu_ref(aluctr, a, b, c);
                m_busy = 1;
                m_left = WIDTH;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 32'(busy), 32'(m_busy));
            chk("done", 32'(done), 32'(m_done));
            chk("d", 32'(d), 32'(m_d));
            chk("e", 32'(e), 32'(m_e));
        end
    end

    task automatic drive(input logic [1:0] op, input logic [WIDTH-1:0] av,
                         input logic [WIDTH-1:0] bv, input logic cv);
        aluctr = op; a = av; b = bv; c = cv;
    endtask

    task automatic wait_done(input string name, output int lat);
        lat = 0;
        while (!done && lat < 20) begin
            @(posedge clk);
            lat++;
            #1;
        end
        if (!done) begin
            errors++;
            checks++;
            $display("FAIL %s_timeout: got done=0 expected done=1", name);
        end
    endtask

    task automatic run_op(input string name, input logic [1:0] op, input logic [WIDTH-1:0] av,
                          input logic [WIDTH-1:0] bv, input logic cv,
                          input logic [WIDTH-1:0] exp_d, input logic exp_e);
        int lat;
        @(posedge clk); #2;
        drive(op, av, bv, cv);
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        drive(2'b00, '0, '0, 1'b0);
        lat = 0;
        #1;
        chk({name, "_busy0"}, 32'(busy), 32'd1);
        while (!done && lat < 20) begin
            @(posedge clk);
            lat++;
            #1;
        end
        chk({name, "_lat"}, 32'(lat), 32'(WIDTH));
        chk({name, "_d"}, 32'(d), 32'(exp_d));
        chk({name, "_e"}, 32'(e), 32'(exp_e));
    endtask

    int lat;
    int first_done;
    int second_done;

    initial begin
        #1 rst_n = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_d", 32'(d), 32'd0);
        chk("rst_e", 32'(e), 32'd0);
        chk_en = 1;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        run_op("add_wrap", 2'b10, 4'b0111, 4'b1001, 1'b0, 4'b0000, 1'b1);
        run_op("sub_pos",  2'b11, 4'b0101, 4'b0011, 1'b1, 4'b0010, 1'b1);
        run_op("sub_neg",  2'b11, 4'b0011, 4'b0101, 1'b1, 4'b1110, 1'b0);
        run_op("and",      2'b00, 4'b1100, 4'b1010, 1'b0, 4'b1000, 1'b0);
        run_op("or_c1",    2'b01, 4'b1100, 4'b1010, 1'b1, 4'b1110, 1'b0);

        // Start pulsed mid-run must be ignored.
        @(posedge clk); #2;
        drive(2'b10, 4'b0001, 4'b0001, 1'b0);
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        drive(2'b00, '0, '0, 1'b0);
        @(posedge clk); #2;
        drive(2'b10, 4'b1111, 4'b0001, 1'b0);
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        wait_done("ignore", lat);
        chk("ignore_d", 32'(d), 32'h2);
        chk("ignore_e", 32'(e), 32'd0);
        repeat (3) @(posedge clk);

        // Start held high: accepted again in each DONE cycle.
        @(posedge clk); #2;
        drive(2'b10, 4'b0011, 4'b0001, 1'b0);
        start = 1'b1;
        first_done = -1;
        second_done = -1;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            if (done && first_done < 0) first_done = i;
            else if (done && second_done < 0) second_done = i;
        end
        start = 1'b0;
        chk("held_first", 32'(first_done), 32'(WIDTH));
        chk("held_gap", 32'(second_done - first_done), 32'(WIDTH + 1));
        chk("held_d", 32'(d), 32'h4);
        repeat (8) @(posedge clk);

        // Reset mid-run aborts with no done.
        @(posedge clk); #2;
        drive(2'b10, 4'b0110, 4'b0101, 1'b1);
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_d", 32'(d), 32'd0);
        chk("abort_e", 32'(e), 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        first_done = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done) first_done++;
        end
        chk("abort_nodone", 32'(first_done), 32'd0);
        run_op("post_rst", 2'b10, 4'b0011, 4'b0100, 1'b0, 4'b0111, 1'b0);

        repeat (3) @(posedge clk);
        chk_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
